apex_exec_monitor: RTL and testbench
====================================

// Module: apex_exec_monitor
// PURPOSE
//  Proof-of-execution flag generator sitting directly downstream of the secure-stack/secure-data monitor.
//  Consumes that monitor's violation/reset output plus CPU/DMA bus activity.
//  Raises EXEC only when the executable region ER=[er_min,er_max] ran atomically from first to last
//  instruction with no violation, and keeps EXEC high only while ER and metadata stay unmodified.
//  EXEC is read by the attestation software (SW-Att) and is covered by the HMAC.
// PARAMETERS
//  META_BASE      16'h0140  base of metadata region (holds er_min/er_max/challenge)
//  META_SIZE      16'h0020  metadata region size in bytes
//  PMEM_BASE      16'hE000  lowest legal program address for ER
//  RESET_HANDLER  16'hFFFE  reset vector PC
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  pc         in   16  current CPU program counter
//  data_addr  in   16  CPU data bus address
//  w_en       in   1   CPU data write strobe
//  dma_en     in   1   DMA bus active
//  dma_addr   in   16  DMA address
//  irq        in   1   interrupt taken by CPU
//  stack_viol in   1   violation/reset output of the upstream secure-stack monitor
//  er_min     in   16  ER first instruction address (from metadata)
//  er_max     in   16  ER last instruction address (from metadata)
//  exec       out  1   proof-of-execution flag
//  abort_cause out 3   cause of last abort; sticky until next ER entry
// BEHAVIOUR
//  - Reset: state=ABORT, exec=0, abort_cause=3'd0 (NONE). All outputs registered; 1-cycle latency from input to output.
//  - cfg_ok = (er_min <= er_max) && (er_min >= PMEM_BASE) && (er_max <= RESET_HANDLER-2).
//    While !cfg_ok: force ABORT, cause=CFG.
//  - viol_any (combinational, priority order for cause):
//    1 STACK = stack_viol
//    2 WRITE = w_en && data_addr in ER or metadata
//    3 DMA   = dma_en && dma_addr in ER or metadata
//    4 IRQ   = irq while pc in ER
//    5 FLOW  = illegal PC (see below)
//  - States: ABORT, MID, DONE; exec = (state==DONE).
//  - ABORT -> MID when pc==er_min && !viol_any.
//    ABORT -> DONE directly if additionally er_min==er_max.
//  - MID: pc==er_max && !viol_any -> DONE.
//    pc outside ER -> ABORT (FLOW). Any other viol_any -> ABORT.
//  - DONE: WRITE/DMA/STACK -> ABORT.
//    pc==er_min -> MID (re-execution clears exec).
//    pc in ER other than er_min/er_max -> ABORT (FLOW, entry not via er_min).
//    pc outside ER is legal.
//  - Simultaneous violation and entry/exit PC: violation wins (ABORT).
//  - abort_cause is loaded on every transition into ABORT and cleared to NONE on ABORT->MID.
//  - pc==RESET_HANDLER: state ABORT (cause unchanged).
//  - rst mid-operation: ABORT regardless of state.
//  - Region checks are inclusive [base, base+size-1]. ER checks are inclusive [er_min, er_max].
//    16-bit compare, no wrap.
// STRUCTURE
//  - Package apex_pkg: state enum {ABORT,MID,DONE}; cause codes NONE=0,STACK=1,WRITE=2,DMA=3,IRQ=4,FLOW=5,CFG=6;
//    META_*/PMEM_BASE defaults.
//  - Sub-module apex_range_chk: addr, lo, hi -> in_range; instanced for ER and metadata on CPU and DMA addresses.
//  - Top: violation decode (combinational) + 3-state FSM + cause register.
// TESTING
//  - Clean run (er_min=E100, er_max=E1FE): pc steps E100..E1FE -> exec=1 one cycle after pc==E1FE; cause=NONE.
//  - Early exit (pc E100 -> E150 -> C000) -> exec stays 0; cause=FLOW after the C000 cycle.
//  - DONE, then w_en with data_addr=E120 -> exec=0 next cycle, cause=WRITE. Same check with dma_addr=0145 -> cause=DMA.
//  - irq asserted at pc=E110 in MID -> ABORT, cause=IRQ. Same cycle stack_viol=1 -> cause=STACK (priority).
//  - er_min=E200, er_max=E100 -> exec never set, cause=CFG.
//  - rst asserted while in DONE -> exec=0, cause=NONE next cycle.
//  - er_min==er_max=E100, pc=E100 -> exec=1 next cycle.

Source files
------------

// File: rtl/apex_pkg.sv
// Shared types and address constants for the APEX proof-of-execution monitor.
package apex_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CAUSE_W = 3;

    localparam logic [ADDR_W-1:0] META_BASE     = 16'h0140;
    localparam logic [ADDR_W-1:0] META_SIZE     = 16'h0020;
    localparam logic [ADDR_W-1:0] PMEM_BASE     = 16'hE000;
    localparam logic [ADDR_W-1:0] RESET_HANDLER = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_ABORT = 2'd0,
        ST_MID   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_STACK = 3'd1,
        CAUSE_WRITE = 3'd2,
        CAUSE_DMA   = 3'd3,
        CAUSE_IRQ   = 3'd4,
        CAUSE_FLOW  = 3'd5,
        CAUSE_CFG   = 3'd6
    } cause_t;

endpackage

// File: rtl/apex_range_chk.sv
// Inclusive unsigned range check: lo <= addr <= hi, no wrap-around.
module apex_range_chk
    import apex_pkg::*;
#(
    parameter int unsigned W = ADDR_W
) (
    input  logic [W-1:0] addr,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic         in_range
);

    assign in_range = (addr >= lo) && (addr <= hi);

endmodule

// File: rtl/apex_exec_monitor.sv
// Proof-of-execution flag: EXEC rises only after ER ran atomically from er_min to er_max
// and falls as soon as ER or metadata can no longer be trusted.
module apex_exec_monitor
    import apex_pkg::*;
#(
    parameter logic [ADDR_W-1:0] META_BASE_P     = META_BASE,
    parameter logic [ADDR_W-1:0] META_SIZE_P     = META_SIZE,
    parameter logic [ADDR_W-1:0] PMEM_BASE_P     = PMEM_BASE,
    parameter logic [ADDR_W-1:0] RESET_HANDLER_P = RESET_HANDLER
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                w_en,
    input  logic                dma_en,
    input  logic [ADDR_W-1:0]   dma_addr,
    input  logic                irq,
    input  logic                stack_viol,
    input  logic [ADDR_W-1:0]   er_min,
    input  logic [ADDR_W-1:0]   er_max,
    output logic                exec,
    output logic [CAUSE_W-1:0]  abort_cause
);

    localparam logic [ADDR_W-1:0] META_LAST  = META_BASE_P + META_SIZE_P - 16'd1;
    localparam logic [ADDR_W-1:0] ER_MAX_LIM = RESET_HANDLER_P - 16'd2;

    state_t state;

    logic pc_in_er, data_in_er, data_in_meta, dma_in_er, dma_in_meta;
    logic cfg_ok_c;
    logic stack_c, write_c, dma_c, irq_c, flow_c;
    logic viol_any_c, done_viol_c;
    logic at_min_c, at_max_c, single_c;
    cause_t cause_c;

    apex_range_chk u_pc_er     (.addr(pc),        .lo(er_min),      .hi(er_max),    .in_range(pc_in_er));
    apex_range_chk u_data_er   (.addr(data_addr), .lo(er_min),      .hi(er_max),    .in_range(data_in_er));
    apex_range_chk u_data_meta (.addr(data_addr), .lo(META_BASE_P), .hi(META_LAST), .in_range(data_in_meta));
    apex_range_chk u_dma_er    (.addr(dma_addr),  .lo(er_min),      .hi(er_max),    .in_range(dma_in_er));
    apex_range_chk u_dma_meta  (.addr(dma_addr),  .lo(META_BASE_P), .hi(META_LAST), .in_range(dma_in_meta));

    // Violation decode; FLOW legality depends on where we are in the ER run.
    always_comb begin
        cfg_ok_c = (er_min <= er_max) && (er_min >= PMEM_BASE_P) && (er_max <= ER_MAX_LIM);
        at_min_c = (pc == er_min);
        at_max_c = (pc == er_max);
        single_c = (er_min == er_max);
        stack_c  = stack_viol;
        write_c  = w_en && (data_in_er || data_in_meta);
        dma_c    = dma_en && (dma_in_er || dma_in_meta);
        irq_c    = irq && pc_in_er;
        flow_c   = 1'b0;
        case (state)
            ST_MID:  flow_c = !pc_in_er;
            ST_DONE: flow_c = pc_in_er && !at_min_c && !at_max_c;
            default: flow_c = 1'b0;
        endcase
        viol_any_c  = stack_c || write_c || dma_c || irq_c || flow_c;
        // In DONE an interrupt only matters when it coincides with a re-entry at er_min.
        done_viol_c = stack_c || write_c || dma_c || flow_c || (irq_c && at_min_c);
        if (stack_c)      cause_c = CAUSE_STACK;
        else if (write_c) cause_c = CAUSE_WRITE;
        else if (dma_c)   cause_c = CAUSE_DMA;
        else if (irq_c)   cause_c = CAUSE_IRQ;
        else if (flow_c)  cause_c = CAUSE_FLOW;
        else              cause_c = CAUSE_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ABORT;
            exec        <= 1'b0;
            abort_cause <= CAUSE_NONE;
        end else if (!cfg_ok_c) begin
            state       <= ST_ABORT;
            exec        <= 1'b0;
            abort_cause <= CAUSE_CFG;
        end else if (pc == RESET_HANDLER_P) begin
            state <= ST_ABORT;
            exec  <= 1'b0;
        end else begin
            case (state)
                ST_ABORT: begin
                    if (at_min_c && !viol_any_c) begin
                        abort_cause <= CAUSE_NONE;
                        state       <= single_c ? ST_DONE : ST_MID;
                        exec        <= single_c;
                    end
                end
                ST_MID: begin
                    if (viol_any_c) begin
                        state       <= ST_ABORT;
                        exec        <= 1'b0;
                        abort_cause <= cause_c;
                    end else if (at_max_c) begin
                        state <= ST_DONE;
                        exec  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (done_viol_c) begin
                        state       <= ST_ABORT;
                        exec        <= 1'b0;
                        abort_cause <= cause_c;
                    end else if (at_min_c && !single_c) begin
                        state       <= ST_MID;
                        exec        <= 1'b0;
                        abort_cause <= CAUSE_NONE;
                    end
                end
                default: begin
                    state <= ST_ABORT;
                    exec  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apex_exec_monitor.sv
// Directed bench for apex_exec_monitor with hand-computed expectations.
module tb_apex_exec_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, data_addr, dma_addr, er_min, er_max;
    logic        w_en, dma_en, irq, stack_viol;
    logic        exec;
    logic [2:0]  abort_cause;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [15:0] C_NONE = 16'd0, C_STACK = 16'd1, C_WRITE = 16'd2,
                            C_DMA = 16'd3, C_IRQ = 16'd4, C_FLOW = 16'd5, C_CFG = 16'd6;

    apex_exec_monitor dut (
        .clk(clk), .rst(rst), .pc(pc), .data_addr(data_addr), .w_en(w_en),
        .dma_en(dma_en), .dma_addr(dma_addr), .irq(irq), .stack_viol(stack_viol),
        .er_min(er_min), .er_max(er_max), .exec(exec), .abort_cause(abort_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Let one active edge consume the current inputs, then sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_er();
        for (int a = 16'hE100; a <= 16'hE1FE; a += 2) begin
            pc = 16'(a);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; pc = 16'h0000; data_addr = 16'h0000; dma_addr = 16'h0000;
        w_en = 1'b0; dma_en = 1'b0; irq = 1'b0; stack_viol = 1'b0;
        er_min = 16'hE100; er_max = 16'hE1FE;
        step();
        check("reset_exec", 16'(exec), 16'd0);
        check("reset_cause", 16'(abort_cause), C_NONE);
        rst = 1'b0;

        // Clean run, watched part-way through
        pc = 16'hE100; step();
        pc = 16'hE150; step();
        check("mid_exec", 16'(exec), 16'd0);
        run_er();
        check("clean_exec", 16'(exec), 16'd1);
        check("clean_cause", 16'(abort_cause), C_NONE);
        pc = 16'hC000; step();
        check("done_outside_exec", 16'(exec), 16'd1);

        // Write into ER after completion
        w_en = 1'b1; data_addr = 16'hE120; step();
        w_en = 1'b0;
        check("write_exec", 16'(exec), 16'd0);
        check("write_cause", 16'(abort_cause), C_WRITE);

        // DMA just past metadata is harmless; inside metadata aborts
        run_er(); pc = 16'hC000; step();
        dma_en = 1'b1; dma_addr = 16'h0160; step();
        check("dma_edge_exec", 16'(exec), 16'd1);
        dma_addr = 16'h0145; step();
        dma_en = 1'b0;
        check("dma_exec", 16'(exec), 16'd0);
        check("dma_cause", 16'(abort_cause), C_DMA);

        // Early exit
        pc = 16'hE100; step();
        check("entry_clears_cause", 16'(abort_cause), C_NONE);
        pc = 16'hE150; step();
        pc = 16'hC000; step();
        check("early_exit_exec", 16'(exec), 16'd0);
        check("early_exit_cause", 16'(abort_cause), C_FLOW);

        // IRQ inside ER, then IRQ together with a stack violation
        pc = 16'hE100; step();
        pc = 16'hE110; irq = 1'b1; step();
        irq = 1'b0;
        check("irq_cause", 16'(abort_cause), C_IRQ);
        pc = 16'hE100; step();
        pc = 16'hE110; irq = 1'b1; stack_viol = 1'b1; step();
        irq = 1'b0; stack_viol = 1'b0;
        check("stack_prio_cause", 16'(abort_cause), C_STACK);

        // Violation on the exit PC wins over completion
        pc = 16'hE100; step();
        pc = 16'hE1FE; w_en = 1'b1; data_addr = 16'h0140; step();
        w_en = 1'b0;
        check("exit_viol_exec", 16'(exec), 16'd0);
        check("exit_viol_cause", 16'(abort_cause), C_WRITE);

        // Jumping into the middle of ER from DONE
        run_er(); pc = 16'hC000; step();
        pc = 16'hE150; step();
        check("done_flow_exec", 16'(exec), 16'd0);
        check("done_flow_cause", 16'(abort_cause), C_FLOW);

        // Reset while DONE
        run_er();
        check("pre_rst_exec", 16'(exec), 16'd1);
        rst = 1'b1; step();
        rst = 1'b0;
        check("rst_exec", 16'(exec), 16'd0);
        check("rst_cause", 16'(abort_cause), C_NONE);

        // Inverted ER configuration
        er_min = 16'hE200; er_max = 16'hE100;
        pc = 16'hE200; step();
        pc = 16'hE100; step();
        check("cfg_exec", 16'(exec), 16'd0);
        check("cfg_cause", 16'(abort_cause), C_CFG);

        // Single-instruction ER
        er_min = 16'hE100; er_max = 16'hE100;
        pc = 16'hC000; step();
        pc = 16'hE100; step();
        check("single_exec", 16'(exec), 16'd1);
        check("single_cause", 16'(abort_cause), C_NONE);

        // Reset handler drops EXEC but keeps the cause
        pc = 16'hFFFE; step();
        check("rstvec_exec", 16'(exec), 16'd0);
        check("rstvec_cause", 16'(abort_cause), C_NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
